// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host/RAM/control-FSM bundle for the program loader
// master is the host side driving bytes; slave is the loader itself.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              iram_we;
  logic [ADDR_W-1:0] iram_addr;
  logic [31:0]       iram_wdata;
  logic              cpu_reset;
  logic              cpu_enable;
  logic              cpu_finish;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  words_loaded;

  modport master (
    output start, rx_data, rx_valid, cpu_finish,
    input  rx_ready, iram_we, iram_addr, iram_wdata, cpu_reset, cpu_enable,
           busy, done, error, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid, cpu_finish,
    output rx_ready, iram_we, iram_addr, iram_wdata, cpu_reset, cpu_enable,
           busy, done, error, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader feeding instruction RAM and the control FSM
// Header is a 16-bit little-endian word count, followed by little-endian 32-bit words.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_CHECK, S_DATA,
    S_WRITE, S_RELEASE, S_RUN, S_HALT, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**ADDR_W);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] len;
  logic [1:0]       idx;
  logic             acc;
  logic [CNT_W-1:0] wl_inc;

  assign acc    = bus.rx_valid && bus.rx_ready;
  assign wl_inc = bus.words_loaded + CNT_W'(1);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_HALT, S_ERR: if (bus.start) nxt = S_LEN_LO;
      S_LEN_LO:  if (acc) nxt = S_LEN_HI;
      S_LEN_HI:  if (acc) nxt = S_CHECK;
      S_CHECK:   nxt = (len == '0 || len > DEPTH) ? S_ERR : S_DATA;
      S_DATA:    if (acc && idx == 2'd3) nxt = S_WRITE;
      S_WRITE:   nxt = (wl_inc == len) ? S_RELEASE : S_DATA;
      S_RELEASE: nxt = S_RUN;
      S_RUN:     if (bus.cpu_finish) nxt = S_HALT;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      len              <= '0;
      idx              <= '0;
      bus.rx_ready     <= 1'b0;
      bus.iram_we      <= 1'b0;
      bus.iram_addr    <= '0;
      bus.iram_wdata   <= '0;
      bus.cpu_reset    <= 1'b1;
      bus.cpu_enable   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      state          <= nxt;
      bus.rx_ready   <= (nxt == S_LEN_LO) || (nxt == S_LEN_HI) || (nxt == S_DATA);
      bus.iram_we    <= (nxt == S_WRITE);
      bus.cpu_reset  <= !((nxt == S_RUN) || (nxt == S_HALT));
      bus.cpu_enable <= (nxt == S_RELEASE) || (nxt == S_RUN) || (nxt == S_HALT);
      bus.busy       <= (nxt == S_LEN_LO) || (nxt == S_LEN_HI) || (nxt == S_CHECK) ||
                        (nxt == S_DATA) || (nxt == S_WRITE) || (nxt == S_RELEASE) ||
                        (nxt == S_RUN);
      bus.done       <= (nxt == S_HALT);
      bus.error      <= (nxt == S_ERR);
      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (bus.start) begin
            bus.words_loaded <= '0;
            idx              <= '0;
          end
        end
        S_LEN_LO: if (acc) len[7:0] <= bus.rx_data;
        S_LEN_HI: if (acc) len[15:8] <= bus.rx_data;
        S_DATA: begin
          if (acc) begin
            bus.iram_wdata[{idx, 3'b000} +: 8] <= bus.rx_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) bus.iram_addr <= bus.words_loaded[ADDR_W-1:0];
          end
        end
        S_WRITE: begin
          bus.words_loaded <= wl_inc;
          idx              <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
// Expected RAM writes come from a queue filled as words are generated.
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rel_cnt = 0;
  int alt_gap = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.cpu_reset && bus.cpu_enable) rel_cnt++;
      if (bus.busy && !bus.cpu_enable)
        chk("cpu_held", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd2);
      if (bus.iram_we) begin
        chk("we_rx_ready", 32'(bus.rx_ready), 32'd0);
        if (exp_addr.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
        else begin
          chk("we_addr", 32'(bus.iram_addr), exp_addr.pop_front());
          chk("we_data", bus.iram_wdata, exp_data.pop_front());
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int budget;
    bit got;
    gap = (alt_gap != 0) ? 1 : int'($urandom_range(0, 2));
    repeat (gap) @(posedge clk);
    #1 bus.rx_data = b;
    bus.rx_valid = 1'b1;
    budget = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge clk);
      if (bus.rx_ready) got = 1'b1;
      else begin
        budget++;
        if (budget > 50) begin
          chk("rx_timeout", 32'd0, 32'd1);
          got = 1'b1;
        end
      end
    end
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic send_header(input int len);
    logic [15:0] h;
    h = 16'(len);
    send_byte(h[7:0]);
    send_byte(h[15:8]);
  endtask

  task automatic wait_error();
    int n;
    n = 0;
    while (!bus.error && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("err_flag", 32'(bus.error), 32'd1);
    chk("err_busy", 32'(bus.busy), 32'd0);
    chk("err_cpu", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd2);
    chk("err_ready", 32'(bus.rx_ready), 32'd0);
  endtask

  task automatic load(input int len, input bit fixed, input logic [31:0] fw);
    logic [31:0] w;
    int rel0;
    pulse_start();
    send_header(len);
    @(negedge clk);
    chk("load_cpu", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd2);
    if (len == 0 || len > 2**ADDR_W) begin
      wait_error();
      return;
    end
    rel0 = rel_cnt;
    for (int i = 0; i < len; i++) begin
      w = fixed ? fw : $urandom;
      exp_addr.push_back(32'(i));
      exp_data.push_back(w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    @(negedge clk);
    chk("lat_we", 32'(bus.iram_we), 32'd1);
    chk("last_addr", 32'(bus.iram_addr), 32'(len - 1));
    @(negedge clk);
    chk("lat_release", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd3);
    @(negedge clk);
    chk("lat_run", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd1);
    chk("words_loaded", 32'(bus.words_loaded), 32'(len));
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_error", 32'(bus.error), 32'd0);
    chk("exp_drained", 32'(exp_addr.size()), 32'd0);
    chk("release_once", 32'(rel_cnt - rel0), 32'd1);
  endtask

  task automatic finish_run();
    @(posedge clk); #1 bus.cpu_finish = 1'b1;
    @(posedge clk); #1 bus.cpu_finish = 1'b0;
    @(negedge clk);
    chk("halt_done", 32'(bus.done), 32'd1);
    chk("halt_busy", 32'(bus.busy), 32'd0);
    chk("halt_cpu", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bus.start = 1'b0;
    bus.rx_data = 8'd0;
    bus.rx_valid = 1'b0;
    bus.cpu_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_we", 32'(bus.iram_we), 32'd0);
    chk("rst_addr", 32'(bus.iram_addr), 32'd0);
    chk("rst_wdata", bus.iram_wdata, 32'd0);
    chk("rst_cpu", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd2);
    chk("rst_status", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
    chk("rst_words", 32'(bus.words_loaded), 32'd0);
    reset = 1'b1;

    load(1, 1'b1, 32'hDEADBEEF);
    finish_run();

    alt_gap = 1;
    load(3, 1'b0, 32'd0);
    alt_gap = 0;
    finish_run();

    load(0, 1'b0, 32'd0);
    load(1, 1'b0, 32'd0);
    finish_run();

    load(257, 1'b0, 32'd0);
    load(256, 1'b0, 32'd0);
    finish_run();

    // One full word plus two bytes, a stray start, then an asynchronous reset.
    pulse_start();
    send_header(2);
    w = $urandom;
    exp_addr.push_back(32'd0);
    exp_data.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    send_byte(8'h5A);
    send_byte(8'hA5);
    pulse_start();
    @(negedge clk);
    chk("ign_start_busy", 32'(bus.busy), 32'd1);
    chk("ign_start_ready", 32'(bus.rx_ready), 32'd1);
    chk("ign_start_words", 32'(bus.words_loaded), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_we", 32'(bus.iram_we), 32'd0);
    chk("arst_cpu", {30'd0, bus.cpu_reset, bus.cpu_enable}, 32'd2);
    chk("arst_status", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
    chk("arst_ready", 32'(bus.rx_ready), 32'd0);
    chk("arst_words", 32'(bus.words_loaded), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    load(2, 1'b0, 32'd0);
    finish_run();

    load(2, 1'b0, 32'd0);
    finish_run();

    repeat (3) begin
      load(int'($urandom_range(1, 6)), 1'b0, 32'd0);
      finish_run();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
